reg_bank_sequencer: RTL and testbench

Eight-entry, 32-bit register bank with a command sequencer that drives the per-word load enables and a shared internal transfer bus. It sits directly upstream of the single-register stage. It accepts LOAD, MOVE, SWAP and READ commands over a valid/ready handshake and executes each one as a short multi-cycle transfer. A combinational peek port exposes any word for debug and verification.

---
 rtl/reg_bank_pkg.sv | 25 ++
 rtl/reg_bank_sequencer_bank_word.sv | 31 +++
 rtl/reg_bank_sequencer.sv | 161 ++++++++++++++++
 tb/tb_reg_bank_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
// Shared definitions for the register-bank sequencer:
//   - default bank geometry (width, word count, address width)
//   - command opcode encoding carried on cmd_op
//   - sequencer state encoding
package reg_bank_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 8;
    localparam int DEF_AW    = 3;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_MOVE = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_SW1  = 3'd2,
        ST_SW2  = 3'd3,
        ST_SW3  = 3'd4
    } state_t;

endpackage

// File: rtl/reg_bank_sequencer_bank_word.sv
// bank_word
// One word of the register bank: a WIDTH-bit register with a load enable.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset, clears the word to 0
//   i_load - load enable; captures i_d on the rising edge
//   i_d    - data to capture
//   o_q    - stored word
module bank_word #(
    parameter int WIDTH = reg_bank_pkg::DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_bank_sequencer.sv
// reg_bank_sequencer
// Register bank of NREGS words with a command sequencer. Commands (READ,
// LOAD, MOVE, SWAP) are accepted over a valid/ready handshake, latched, and
// executed as short multi-cycle transfers through a shared write path that
// asserts at most one word's load enable per cycle.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   cmd_valid / cmd_ready - command handshake
//   cmd_op/dst/src/data   - command fields, captured at accept
//   result, result_valid  - registered READ data and its one-cycle strobe
//   busy                  - command in progress (inverse of cmd_ready)
//   peek_addr, peek_data  - combinational debug read of any word
module reg_bank_sequencer
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_src,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    input  logic [AW-1:0]    peek_addr,
    output logic [WIDTH-1:0] peek_data
);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [AW-1:0]    r_dst;
    logic [AW-1:0]    r_src;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_temp;
    logic [WIDTH-1:0] r_result;
    logic             r_result_valid;

    logic             w_ready;
    logic             w_accept;
    logic             w_wen;
    logic [AW-1:0]    w_wsel;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_bus;
    logic [NREGS-1:0] w_we;
    logic [WIDTH-1:0] w_words [NREGS];

    assign w_accept = cmd_valid && w_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (cmd_op == OP_SWAP) ? ST_SW1 : ST_EXEC;
                end
            end
            ST_EXEC: w_next = ST_IDLE;
            ST_SW1:  w_next = ST_SW2;
            ST_SW2:  w_next = ST_SW3;
            ST_SW3:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output logic: handshake and the single shared write path into the bank
    always_comb begin
        w_ready = 1'b0;
        w_wen   = 1'b0;
        w_wsel  = r_dst;
        w_wdata = r_data;
        w_bus   = w_words[r_src];
        case (r_state)
            ST_IDLE: w_ready = 1'b1;
            ST_EXEC: begin
                if (r_op == OP_LOAD) begin
                    w_wen = 1'b1;
                end else if (r_op == OP_MOVE) begin
                    w_wen   = 1'b1;
                    w_wdata = w_bus;
                end
            end
            ST_SW2: begin
                w_wen   = 1'b1;
                w_wdata = w_bus;
            end
            ST_SW3: begin
                // Second half of the swap lands the saved first operand on src
                w_wen   = 1'b1;
                w_wsel  = r_src;
                w_wdata = r_temp;
            end
            default: ;
        endcase
    end

    // Command latch: fields are frozen at accept so later input changes are ignored
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_op   <= cmd_op;
            r_dst  <= cmd_dst;
            r_src  <= cmd_src;
            r_data <= cmd_data;
        end
    end

    // Swap temp, READ result and its strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            r_temp         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (r_state == ST_SW1) begin
                r_temp <= w_words[r_dst];
            end
            if (r_state == ST_EXEC && r_op == OP_READ) begin
                r_result       <= w_bus;
                r_result_valid <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_word
            assign w_we[gi] = w_wen && (w_wsel == AW'(gi));
            bank_word #(.WIDTH(WIDTH)) u_word (
                .clock  (clock),
                .reset  (reset),
                .i_load (w_we[gi]),
                .i_d    (w_wdata),
                .o_q    (w_words[gi])
            );
        end
    endgenerate

    assign cmd_ready    = w_ready;
    assign busy         = !w_ready;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign peek_data    = w_words[peek_addr];

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// tb_reg_bank_sequencer
// Directed bench for reg_bank_sequencer: inputs change 1 ns after each
// rising edge, outputs are checked in the same window.
module tb_reg_bank_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_src;
    logic [31:0] cmd_data;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic [2:0]  peek_addr;
    logic [31:0] peek_data;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] T_READ = 2'b00;
    localparam logic [1:0] T_LOAD = 2'b01;
    localparam logic [1:0] T_MOVE = 2'b10;
    localparam logic [1:0] T_SWAP = 2'b11;

    always #20 clock = ~clock;

    reg_bank_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_dst      (cmd_dst),
        .cmd_src      (cmd_src),
        .cmd_data     (cmd_data),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .peek_addr    (peek_addr),
        .peek_data    (peek_data)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_peek(input string tag, input logic [2:0] a, input logic [31:0] exp);
        peek_addr = a;
        #1;
        chk(tag, peek_data, exp);
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, {31'd0, exp});
        chk({tag, "_busy"},  {31'd0, busy},      {31'd0, !exp});
    endtask

    // Issue one command and verify cmd_ready stays low for exactly nbusy cycles
    task automatic issue(input string tag, input logic [1:0] op, input logic [2:0] dst,
                         input logic [2:0] src, input logic [31:0] data, input int nbusy);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src   = src;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < nbusy; i++) begin
            chk_ready(tag, 1'b0);
            step();
        end
        chk_ready(tag, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = T_READ;
        cmd_dst   = 3'd0;
        cmd_src   = 3'd0;
        cmd_data  = 32'd0;
        peek_addr = 3'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        for (int a = 0; a < 8; a++) begin
            chk_peek("rst_peek", 3'(a), 32'h0000_0000);
        end
        chk_ready("rst", 1'b1);
        chk("rst_rv", {31'd0, result_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        step();
        chk_ready("rst_after", 1'b1);

        // LOAD then READ
        issue("load3", T_LOAD, 3'd3, 3'd0, 32'hACA6_ACA6, 1);
        chk_peek("load3_peek", 3'd3, 32'hACA6_ACA6);

        cmd_valid = 1'b1;
        cmd_op    = T_READ;
        cmd_src   = 3'd3;
        step();
        cmd_valid = 1'b0;
        chk_ready("read3_k", 1'b0);
        chk("read3_rv_k", {31'd0, result_valid}, 32'd0);
        step();
        chk_ready("read3_k1", 1'b1);
        chk("read3_rv_k1", {31'd0, result_valid}, 32'd1);
        chk("read3_result", result, 32'hACA6_ACA6);
        step();
        chk("read3_rv_k2", {31'd0, result_valid}, 32'd0);
        chk("read3_hold", result, 32'hACA6_ACA6);

        // SWAP with a different command held on cmd_valid during execution
        issue("load1", T_LOAD, 3'd1, 3'd0, 32'h1111_1111, 1);
        issue("load2", T_LOAD, 3'd2, 3'd0, 32'h2222_2222, 1);
        cmd_valid = 1'b1;
        cmd_op    = T_SWAP;
        cmd_dst   = 3'd1;
        cmd_src   = 3'd2;
        step();
        cmd_op   = T_LOAD;
        cmd_dst  = 3'd7;
        cmd_data = 32'hDEAD_BEEF;
        chk_ready("swap_k", 1'b0);
        step();
        chk_ready("swap_k1", 1'b0);
        chk_peek("swap_k1_r1", 3'd1, 32'h1111_1111);
        step();
        chk_ready("swap_k2", 1'b0);
        chk_peek("swap_k2_r1", 3'd1, 32'h2222_2222);
        chk_peek("swap_k2_r2", 3'd2, 32'h2222_2222);
        step();
        chk_ready("swap_k3", 1'b1);
        chk_peek("swap_r1", 3'd1, 32'h2222_2222);
        chk_peek("swap_r2", 3'd2, 32'h1111_1111);
        chk_peek("held_not_taken", 3'd7, 32'h0000_0000);
        step();
        cmd_valid = 1'b0;
        chk_ready("held_acc", 1'b0);
        step();
        chk_peek("held_load_r7", 3'd7, 32'hDEAD_BEEF);

        // MOVE and degenerate MOVE/SWAP
        issue("move25", T_MOVE, 3'd5, 3'd2, 32'h0, 1);
        chk_peek("move_r5", 3'd5, 32'h1111_1111);
        chk_peek("move_r2", 3'd2, 32'h1111_1111);
        issue("load4", T_LOAD, 3'd4, 3'd0, 32'h4444_4444, 1);
        issue("load6", T_LOAD, 3'd6, 3'd0, 32'h6666_6666, 1);
        issue("move44", T_MOVE, 3'd4, 3'd4, 32'h0, 1);
        chk_peek("move44_r4", 3'd4, 32'h4444_4444);
        issue("swap66", T_SWAP, 3'd6, 3'd6, 32'h0, 3);
        chk_peek("swap66_r6", 3'd6, 32'h6666_6666);

        // Reset in SW2 aborts the swap and clears everything
        cmd_valid = 1'b1;
        cmd_op    = T_SWAP;
        cmd_dst   = 3'd1;
        cmd_src   = 3'd2;
        step();
        cmd_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            chk_peek("swrst_peek", 3'(a), 32'h0000_0000);
        end
        chk_ready("swrst", 1'b1);
        chk("swrst_result", result, 32'd0);

        // Command fields are latched at accept
        cmd_valid = 1'b1;
        cmd_op    = T_LOAD;
        cmd_dst   = 3'd0;
        cmd_data  = 32'h1234_5678;
        step();
        cmd_valid = 1'b0;
        cmd_dst   = 3'd7;
        cmd_data  = 32'hFFFF_FFFF;
        step();
        chk_peek("latch_r0", 3'd0, 32'h1234_5678);
        chk_peek("latch_r7", 3'd7, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
